// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the LSU AXI read-channel arbiter.
// Contents:
//   arb_state_e   - address-phase state (IDLE: pick a winner, ISSUE: drive AR)
//   AR_SIZE_8B    - ARSIZE encoding for 8-byte beats
//   AR_BURST_INCR - ARBURST encoding for incrementing bursts
//   AR_REGION_DEF - default ARREGION
//   ar_size_for() - ARSIZE encoding for an arbitrary data-bus width
package lsu_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  localparam logic [2:0] AR_SIZE_8B    = 3'b011;
  localparam logic [1:0] AR_BURST_INCR = 2'b01;
  localparam logic [3:0] AR_REGION_DEF = 4'd0;

  // Bytes-per-beat encoding (log2 of bus width in bytes).
  function automatic logic [2:0] ar_size_for(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/lsu_rr_arb.sv
// Combinational round-robin grant.
// Ports:
//   req - request vector, one bit per requester
//   ptr - index with highest priority this cycle (must be < N)
//   gnt - one-hot grant (all zero when nothing requests)
//   idx - binary index of the granted requester
//   any - at least one request is present
module lsu_rr_arb #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic hit_s;

  // Scan offsets 0..N-1 from ptr; the first requesting slot wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    hit_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        hit_s  = !any && req[i] && (((int'(ptr) + k) % N) == i);
        gnt[i] = gnt[i] | hit_s;
        idx    = hit_s ? IDX_W'(i) : idx;
        any    = any | hit_s;
      end
    end
  end

endmodule

// File: rtl/lsu_axi_rd_arb.sv
// Shares one AXI read-address / read-data channel pair between NUM_REQ LSU
// load requesters. Bursts are granted round-robin, tagged with the requester
// index as ARID, and limited to MAX_OUTST outstanding bursts per requester.
// Returning R beats are steered to their owner by RID; beats carrying an ID
// outside the requester range are accepted and dropped.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   req_arvalid/araddr/arlen/arready - per-requester AR request, packed buses
//   req_rvalid/rready     - per-requester R handshake (one-hot valid)
//   req_rdata/rresp/rlast - R payload shared by all requesters
//   AR*/R*                - AXI read-address and read-data channels
//   idle                  - no pending request, no AR in flight, nothing outstanding
module lsu_axi_rd_arb
  import lsu_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int AWID_WIDTH   = 4,
  parameter int AWADDR_WIDTH = 32,
  parameter int WDATA_WIDTH  = 64,
  parameter int MAX_OUTST    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_arvalid,
  input  logic [NUM_REQ*AWADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]            req_arlen,
  output logic [NUM_REQ-1:0]              req_arready,
  output logic [NUM_REQ-1:0]              req_rvalid,
  input  logic [NUM_REQ-1:0]              req_rready,
  output logic [WDATA_WIDTH-1:0]          req_rdata,
  output logic [1:0]                      req_rresp,
  output logic                            req_rlast,
  output logic [AWID_WIDTH-1:0]           ARID,
  output logic [AWADDR_WIDTH-1:0]         ARADDR,
  output logic [7:0]                      ARLEN,
  output logic [2:0]                      ARSIZE,
  output logic [1:0]                      ARBURST,
  output logic [3:0]                      ARREGION,
  output logic                            ARVALID,
  input  logic                            ARREADY,
  input  logic [AWID_WIDTH-1:0]           RID,
  input  logic [WDATA_WIDTH-1:0]          RDATA,
  input  logic [1:0]                      RRESP,
  input  logic                            RLAST,
  input  logic                            RVALID,
  output logic                            RREADY,
  output logic                            idle
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  arb_state_e               state_r;
  logic [PTR_W-1:0]         ptr_r;
  logic [PTR_W-1:0]         arsel_r;
  logic [AWID_WIDTH-1:0]    arid_r;
  logic [AWADDR_WIDTH-1:0]  araddr_r;
  logic [7:0]               arlen_r;
  logic                     arvalid_r;
  logic [CNT_W-1:0]         outst_r [NUM_REQ];

  logic [NUM_REQ-1:0]       elig_s;
  logic [NUM_REQ-1:0]       gnt_s;
  logic [PTR_W-1:0]         win_s;
  logic                     any_s;
  logic [AWADDR_WIDTH-1:0]  win_addr_s;
  logic [7:0]               win_len_s;
  logic                     ar_hs_s;
  logic                     rid_ok_s;
  logic                     rready_s;
  logic [NUM_REQ-1:0]       rvalid_s;
  logic [NUM_REQ-1:0]       inc_s;
  logic [NUM_REQ-1:0]       dec_s;
  logic                     any_outst_s;

  // A requester may compete only while it has room for another burst.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_s[i] = req_arvalid[i] && (outst_r[i] < CNT_W'(MAX_OUTST));
    end
  end

  lsu_rr_arb #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_rr_arb (
    .req (elig_s),
    .ptr (ptr_r),
    .gnt (gnt_s),
    .idx (win_s),
    .any (any_s)
  );

  // Select the winner's address and length (one-hot AND-OR mux).
  always_comb begin
    win_addr_s = '0;
    win_len_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_addr_s = win_addr_s | ({AWADDR_WIDTH{gnt_s[i]}} & req_araddr[i*AWADDR_WIDTH +: AWADDR_WIDTH]);
      win_len_s  = win_len_s  | ({8{gnt_s[i]}} & req_arlen[i*8 +: 8]);
    end
  end

  // Address-phase FSM: latch the winner in IDLE, hold AR stable in ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      arvalid_r <= 1'b0;
      arsel_r   <= '0;
      arid_r    <= '0;
      araddr_r  <= '0;
      arlen_r   <= '0;
      ptr_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            arsel_r   <= win_s;
            arid_r    <= AWID_WIDTH'(win_s);
            araddr_r  <= win_addr_s;
            arlen_r   <= win_len_s;
            arvalid_r <= 1'b1;
            state_r   <= ISSUE;
          end
        end
        ISSUE: begin
          if (ARREADY) begin
            arvalid_r <= 1'b0;
            // Priority moves to the requester after the one just issued.
            ptr_r     <= (arsel_r == PTR_W'(NUM_REQ - 1)) ? '0 : arsel_r + PTR_W'(1);
            state_r   <= IDLE;
          end
        end
        default: begin
          arvalid_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign ar_hs_s = arvalid_r && ARREADY;

  // Steer R beats to the owner; out-of-range IDs are sunk with RREADY=1.
  always_comb begin
    rvalid_s = '0;
    rready_s = 1'b0;
    rid_ok_s = (32'(RID) < 32'(NUM_REQ));
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid_s[i] = RVALID && (32'(RID) == 32'(i));
      rready_s    = rready_s | ((32'(RID) == 32'(i)) && req_rready[i]);
    end
  end

  // Per-requester counter events: AR accepted, last beat of a burst accepted.
  always_comb begin
    inc_s = '0;
    dec_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc_s[i] = ar_hs_s && (arsel_r == PTR_W'(i));
      dec_s[i] = RVALID && RREADY && RLAST && rid_ok_s && (32'(RID) == 32'(i));
    end
  end

  // Outstanding-burst counters; saturate at both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        outst_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({inc_s[i], dec_s[i]})
          2'b10:   outst_r[i] <= (outst_r[i] == CNT_W'(MAX_OUTST)) ? outst_r[i] : outst_r[i] + CNT_W'(1);
          2'b01:   outst_r[i] <= (outst_r[i] == '0) ? '0 : outst_r[i] - CNT_W'(1);
          default: outst_r[i] <= outst_r[i];
        endcase
      end
    end
  end

  // Any requester still waiting on read data.
  always_comb begin
    any_outst_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      any_outst_s = any_outst_s | (outst_r[i] != '0);
    end
  end

  // The requester handshake completes in the IDLE cycle the winner is latched.
  assign req_arready = ((state_r == IDLE) && !rst) ? gnt_s : '0;

  assign ARVALID   = arvalid_r;
  assign ARID      = arid_r;
  assign ARADDR    = araddr_r;
  assign ARLEN     = arlen_r;
  assign ARSIZE    = (WDATA_WIDTH == 64) ? AR_SIZE_8B : ar_size_for(WDATA_WIDTH);
  assign ARBURST   = AR_BURST_INCR;
  assign ARREGION  = AR_REGION_DEF;

  assign req_rvalid = rvalid_s;
  assign RREADY     = rready_s | !rid_ok_s;
  assign req_rdata  = RDATA;
  assign req_rresp  = RRESP;
  assign req_rlast  = RLAST;

  assign idle = (state_r == IDLE) && !any_outst_s && (req_arvalid == '0);

endmodule
